// File: rtl/a2d_spi_master.sv
// SPI master for a 12-bit ADC. A conversion is two 16-bit transfers separated
// by a 32-clk slave-select gap. The first response is discarded, and the low
// 12 bits of the second response become the result. SCLK runs at clk/32,
// idles high, falls at div==16 and rises at div==31, where MISO is sampled.
module a2d_spi_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        MISO,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        A2D_SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer1,
        StGap,
        StXfer2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  div_q, div_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [2:0]  chnnl_q, chnnl_d;
    logic        ss_n_q, ss_n_d;
    logic        sclk_q, sclk_d;
    logic        cnv_cmplt_q, cnv_cmplt_d;
    logic [11:0] res_q, res_d;

    logic in_xfer;
    logic shift_evt;
    logic last_bit;

    assign in_xfer   = (state_q == StXfer1) || (state_q == StXfer2);
    // Shift coincides with the SCLK rising edge at the end of each bit period.
    assign shift_evt = in_xfer && (div_q == 5'd31);
    assign last_bit  = shift_evt && (bit_cnt_q == 4'd15);

    // Next-state logic for the FSM, the divider, the shift path and all outputs.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        chnnl_d     = chnnl_q;
        ss_n_d      = ss_n_q;
        cnv_cmplt_d = cnv_cmplt_q;
        res_d       = res_q;

        if (state_q != StIdle) begin
            div_d = div_q + 5'd1;
        end

        if (shift_evt) begin
            shreg_d   = {shreg_q[14:0], MISO};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (strt_cnv) begin
                    chnnl_d     = chnnl;
                    shreg_d     = {2'b00, chnnl, 11'h000};
                    cnv_cmplt_d = 1'b0;
                    div_d       = 5'd0;
                    bit_cnt_d   = 4'd0;
                    ss_n_d      = 1'b0;
                    state_d     = StXfer1;
                end
            end
            StXfer1: begin
                if (last_bit) begin
                    ss_n_d  = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                // div wrapped to 0 at the end of XFER1, so 31 marks 32 gap clks.
                if (div_q == 5'd31) begin
                    shreg_d = {2'b00, chnnl_q, 11'h000};
                    div_d   = 5'd0;
                    ss_n_d  = 1'b0;
                    state_d = StXfer2;
                end
            end
            StXfer2: begin
                if (last_bit) begin
                    res_d       = {shreg_q[10:0], MISO};
                    cnv_cmplt_d = 1'b1;
                    ss_n_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered SCLK: low for the second half of each bit period.
        sclk_d = !(((state_d == StXfer1) || (state_d == StXfer2)) && div_d[4]);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            div_q       <= 5'd0;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 16'h8000;
            chnnl_q     <= 3'd0;
            ss_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            cnv_cmplt_q <= 1'b0;
            res_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            chnnl_q     <= chnnl_d;
            ss_n_q      <= ss_n_d;
            sclk_q      <= sclk_d;
            cnv_cmplt_q <= cnv_cmplt_d;
            res_q       <= res_d;
        end
    end

    assign cnv_cmplt = cnv_cmplt_q;
    assign res       = res_q;
    assign A2D_SS_n  = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = shreg_q[15];

endmodule

// File: tb/tb_a2d_spi_master.sv
// Self-checking bench for a2d_spi_master: table of conversions with an ADC
// model and a bus monitor, plus a hand-written mid-conversion reset sequence.
module tb_a2d_spi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        MISO = 1'b1;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        A2D_SS_n;
    logic        SCLK;
    logic        MOSI;

    always #5 clk = ~clk;

    a2d_spi_master dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .MISO      (MISO),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .A2D_SS_n  (A2D_SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI)
    );

    typedef struct {
        string       name;
        logic [2:0]  ch;
        logic [15:0] tx0;   // ADC word during XFER1 (discarded)
        logic [15:0] tx1;   // ADC word during XFER2
        logic [15:0] cmd;
        logic [11:0] res;
        int          poke;  // cycle index of an extra strt_cnv pulse, -1 for none
        int          hold;  // idle cycles after completion before next vector
    } vec_t;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor / ADC model state.
    int          ss_run, sclk_run, since_fall, falls, sclk_bad, viol, xfer_idx;
    logic        ss_prev, sclk_prev, seen_low;
    logic [15:0] tx, mosi_sr, adc_tx0, adc_tx1;
    int          low_runs[$];
    int          high_runs[$];
    logic [15:0] mosi_words[$];

    task automatic clear_mon();
        ss_run = 1; sclk_run = 1; since_fall = -1; falls = 0; sclk_bad = 0;
        viol = 0; xfer_idx = 0; seen_low = 1'b0;
        ss_prev = A2D_SS_n; sclk_prev = SCLK; tx = 16'h0; mosi_sr = 16'h0;
        low_runs.delete(); high_runs.delete(); mosi_words.delete();
    endtask

    // Samples 3 ns after each rising clk edge, clear of test-side activity at negedge.
    always @(posedge clk) begin
        #3;
        if (since_fall >= 0) since_fall++;
        if (A2D_SS_n && !SCLK) viol++;
        if (A2D_SS_n != ss_prev) begin
            if (!ss_prev) low_runs.push_back(ss_run);
            else if (seen_low) high_runs.push_back(ss_run);
            if (!A2D_SS_n) begin
                seen_low   = 1'b1;
                tx         = (xfer_idx == 0) ? adc_tx0 : adc_tx1;
                xfer_idx++;
                since_fall = -1;
            end else begin
                mosi_words.push_back(mosi_sr);
            end
            ss_run  = 1;
            mosi_sr = 16'h0;
        end else begin
            ss_run++;
        end
        if (SCLK != sclk_prev) begin
            if (!SCLK) begin
                falls++;
                if (since_fall >= 0 && since_fall != 32) sclk_bad++;
                since_fall = 0;
                mosi_sr    = {mosi_sr[14:0], MOSI};
                if (!A2D_SS_n) begin
                    MISO = tx[15];
                    tx   = {tx[14:0], 1'b0};
                end
            end else begin
                if (sclk_run != 16) sclk_bad++;
            end
            sclk_run = 1;
        end else begin
            sclk_run++;
        end
        if (A2D_SS_n) MISO = 1'b1;
        ss_prev   = A2D_SS_n;
        sclk_prev = SCLK;
    end

    // Runs one conversion starting at the current negedge; accept edge counts as clk 1.
    task automatic run_conv(input vec_t v);
        int          n;
        logic [11:0] res_before;
        bit          res_moved;
        res_before = res;
        clear_mon();
        adc_tx0  = v.tx0;
        adc_tx1  = v.tx1;
        strt_cnv = 1'b1;
        chnnl    = v.ch;
        @(negedge clk);
        strt_cnv = 1'b0;
        chk({v.name, " cmplt clears on accept"}, cnv_cmplt, 0);
        chk({v.name, " res kept on accept"}, res, res_before);
        n = 0;
        res_moved = 1'b0;
        while (!cnv_cmplt && n < 2000) begin
            if (res !== res_before) res_moved = 1'b1;
            if (n == 5) chnnl = ~v.ch;
            strt_cnv = (n == v.poke);
            if (n == v.poke) chnnl = 3'b000;
            @(negedge clk);
            n++;
        end
        strt_cnv = 1'b0;
        chk({v.name, " latency"}, n + 1, 1057);
        chk({v.name, " res"}, res, v.res);
        chk({v.name, " res stable while busy"}, res_moved, 0);
        chk({v.name, " MOSI words"}, mosi_words.size(), 2);
        chk({v.name, " cmd xfer1"}, (mosi_words.size() > 0) ? mosi_words[0] : 16'hxxxx, v.cmd);
        chk({v.name, " cmd xfer2"}, (mosi_words.size() > 1) ? mosi_words[1] : 16'hxxxx, v.cmd);
        chk({v.name, " SCLK falls"}, falls, 32);
        chk({v.name, " SS low runs"}, low_runs.size(), 2);
        chk({v.name, " SS low xfer1"}, (low_runs.size() > 0) ? low_runs[0] : -1, 512);
        chk({v.name, " SS low xfer2"}, (low_runs.size() > 1) ? low_runs[1] : -1, 512);
        chk({v.name, " SS gap"}, (high_runs.size() == 1) ? high_runs[0] : -1, 32);
        chk({v.name, " SCLK period/low phase errors"}, sclk_bad, 0);
        chk({v.name, " SCLK low while SS high"}, viol, 0);
        repeat (v.hold) @(negedge clk);
        if (v.hold > 0) begin
            chk({v.name, " cmplt sticky"}, cnv_cmplt, 1);
            chk({v.name, " res held"}, res, v.res);
            chk({v.name, " SS idle high"}, A2D_SS_n, 1);
        end
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        vecs[0] = '{"nominal",    3'b101, 16'h0FF0, 16'h0A5C, 16'h2800, 12'hA5C, -1,   4};
        vecs[1] = '{"busy",       3'b101, 16'h1234, 16'h03C3, 16'h2800, 12'h3C3, 200,  4};
        vecs[2] = '{"late_strt",  3'b010, 16'hFFFF, 16'h5A96, 16'h1000, 12'hA96, 1055, 4};
        vecs[3] = '{"b2b_first",  3'b000, 16'h0000, 16'h0123, 16'h0000, 12'h123, -1,   0};
        vecs[4] = '{"b2b_second", 3'b111, 16'h8001, 16'h0ABC, 16'h3800, 12'hABC, -1,   4};
        vecs[5] = '{"zero",       3'b011, 16'hFFFF, 16'hF000, 16'h1800, 12'h000, -1,   4};
        vecs[6] = '{"full",       3'b110, 16'h0000, 16'hFFFF, 16'h3000, 12'hFFF, -1,   4};

        rst = 1'b1; strt_cnv = 1'b0; chnnl = 3'b000;
        adc_tx0 = 16'h0; adc_tx1 = 16'h0;
        clear_mon();
        #12;
        chk("reset SS_n", A2D_SS_n, 1);
        chk("reset SCLK", SCLK, 1);
        chk("reset MOSI", MOSI, 1);
        chk("reset cnv_cmplt", cnv_cmplt, 0);
        chk("reset res", res, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_conv(vecs[i]);

        // Reset 700 clks into a conversion (XFER2, SCLK low phase).
        clear_mon();
        adc_tx0 = 16'h0000; adc_tx1 = 16'h0777;
        strt_cnv = 1'b1; chnnl = 3'b011;
        @(negedge clk);
        strt_cnv = 1'b0;
        repeat (700) @(negedge clk);
        chk("pre-reset SS_n low", A2D_SS_n, 0);
        chk("pre-reset SCLK low", SCLK, 0);
        #1 rst = 1'b1;
        #1;
        chk("async reset SS_n", A2D_SS_n, 1);
        chk("async reset SCLK", SCLK, 1);
        chk("async reset MOSI", MOSI, 1);
        chk("async reset cnv_cmplt", cnv_cmplt, 0);
        chk("async reset res", res, 12'h000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rv = '{"after_reset", 3'b100, 16'h0F0F, 16'h05A5, 16'h2000, 12'h5A5, -1, 4};
        run_conv(rv);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/a2d_spi_master.md
A2D_SPI_MASTER -- requirements
Module: a2d_spi_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all flops on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port strt_cnv, input, 1 bit: one-cycle request to start a conversion.
REQ-004 SHALL have port chnnl, input, 3 bits: ADC channel to convert, sampled on an accepted strt_cnv.
REQ-005 SHALL have port MISO, input, 1 bit: serial data from the ADC.
REQ-006 SHALL have port cnv_cmplt, output, 1 bit: conversion done, sticky.
REQ-007 SHALL have port res, output, 12 bits: conversion result.
REQ-008 SHALL have port A2D_SS_n, output, 1 bit: active-low ADC slave select.
REQ-009 SHALL have port SCLK, output, 1 bit: serial clock to the ADC.
REQ-010 SHALL have port MOSI, output, 1 bit: serial data to the ADC.

Function
REQ-011 SHALL implement states IDLE, XFER1, GAP, XFER2; every output SHALL be a registered signal.
REQ-012 SHALL accept strt_cnv only in IDLE; a strt_cnv in any other state SHALL be ignored.
REQ-013 On an accepted strt_cnv, SHALL do all of the following:
- latch chnnl;
- load the 16-bit shift register with command {2'b00, chnnl, 11'h000};
- clear cnv_cmplt;
- clear the 5-bit divider div to 0;
- enter XFER1 with A2D_SS_n low from the next cycle.
REQ-014 SHALL increment div every clk while in XFER1, GAP and XFER2, wrapping 31 to 0.
REQ-015 SHALL drive SCLK as follows:
- low when div is 16..31 during XFER1/XFER2;
- high otherwise, including in IDLE and GAP.
REQ-016 SHALL drive MOSI from shreg[15] at all times.
REQ-017 SHALL sample MISO on each clk with div==31 during a transfer (coincident with the SCLK rising edge), shifting the register left with MISO entering bit 0.
REQ-018 SHALL end each transfer after exactly 16 shift events (512 clks), counted by a 4-bit bit counter; A2D_SS_n SHALL go high on the same edge.
REQ-019 SHALL keep A2D_SS_n high in GAP for exactly 32 clks, then do all of the following:
- reload the command word;
- clear div;
- enter XFER2 with A2D_SS_n low.
REQ-020 At the end of XFER2 SHALL do all of the following on that same edge:
- load res with shreg[11:0] (the value after the 16th shift);
- set cnv_cmplt;
- return to IDLE.
REQ-021 Latency: cnv_cmplt SHALL rise exactly 1057 clks after the edge that accepted strt_cnv (1 + 512 + 32 + 512).
REQ-022 SHALL hold cnv_cmplt high and res stable until the next accepted strt_cnv; res SHALL NOT change on that accept.
REQ-023 When strt_cnv arrives on the same cycle that cnv_cmplt is set, it is not in IDLE and SHALL be ignored.
REQ-024 A strt_cnv on the first IDLE cycle after completion SHALL be accepted, and cnv_cmplt SHALL then clear.
REQ-025 A change on chnnl during a conversion SHALL NOT affect the command being sent.
REQ-026 SHALL ignore MISO outside XFER1/XFER2; the XFER1 response is discarded.

Reset
REQ-027 While rst is high, SHALL immediately force all of the following:
- state to IDLE;
- A2D_SS_n, SCLK and MOSI high;
- cnv_cmplt to 0;
- res to 12'h000;
- div, bit counter and shift register to 0, except shreg[15], which is forced to 1 so MOSI idles high.
REQ-028 Reset mid-transfer SHALL abort with no partial update of res or cnv_cmplt, and a conversion SHALL be startable on the first clk after rst falls.

Verification
REQ-029 Nominal conversion: chnnl=3'b101 with strt_cnv pulse; the ADC model returns 12'hA5C on the second transfer. Required response:
- MOSI word in both transfers is 16'h2800;
- exactly 32 SCLK falling edges in total;
- cnv_cmplt rises 1057 clks after the accept;
- res becomes 12'hA5C.
REQ-030 Timing check: measure over a conversion. Required response:
- SCLK period is 32 clks, with a 16-clk low phase;
- A2D_SS_n low for 512 clks, then high for 32, then low for 512;
- SCLK high whenever A2D_SS_n is high.
REQ-031 Busy rejection: pulse strt_cnv again 200 clks into XFER1 with chnnl=3'b000. Required response:
- conversion unaffected;
- command still 16'h2800;
- single cnv_cmplt at 1057.
REQ-032 Back-to-back conversions: chnnl=3'b000 then chnnl=3'b111, second strt_cnv on the first IDLE cycle after completion. Required response:
- cnv_cmplt clears on the accept;
- res holds the first value until the second completion;
- second command is 16'h3800.
REQ-033 Reset mid-operation: assert rst at clk 700 (during GAP/XFER2) for 3 clks. Required response:
- A2D_SS_n and SCLK high asynchronously;
- cnv_cmplt=0 and res=0;
- a new strt_cnv completes normally in 1057 clks.
REQ-034 Extreme results: ADC returns 12'h000, then 12'hFFF with upper MISO bits 4'hF. Required response:
- res is 12'h000, then 12'hFFF;
- upper bits are discarded.
